mac_unit: RTL and testbench



---
 rtl/mac_pkg.sv | 10 +
 rtl/mac_mult.sv | 19 +
 rtl/mac_unit.sv | 49 ++++
 tb/tb_mac_unit.sv | 95 +++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared widths and types for the multiply-accumulate lane.
//   MAC_DATA_W : operand width (signed)
//   MAC_ACC_W  : accumulator width (signed). Must be >= 2*MAC_DATA_W.
package mac_pkg;
    localparam int MAC_DATA_W = 8;
    localparam int MAC_ACC_W  = 19;

    typedef logic signed [MAC_DATA_W-1:0] mac_data_t;
    typedef logic signed [MAC_ACC_W-1:0]  mac_acc_t;
endpackage

// File: rtl/mac_mult.sv
// mac_mult: combinational signed DATA_W x DATA_W -> 2*DATA_W multiplier.
// Kept in its own module so it can later be replaced by a DSP primitive or a
// pipelined multiplier without touching the accumulator.
//   a_i : signed operand A
//   b_i : signed operand B
//   p_o : full-precision signed product
module mac_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W
) (
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);
    // Sign-extend both operands to the product width first so the multiply is
    // evaluated at full precision.
    assign p_o = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
endmodule

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate lane.
// Every rising edge: acc <= macc_clear ? sext(A*B) : acc + sext(A*B), with the
// sum wrapping modulo 2^ACC_W. rst_n (synchronous, active-low) wins over all.
//   clk        : clock
//   rst_n      : synchronous active-low reset, clears acc
//   A, B       : signed operands
//   macc_clear : load the product instead of accumulating it
//   acc        : registered signed accumulator
// ACC_W must be >= 2*DATA_W.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = MAC_DATA_W,
    parameter int ACC_W  = MAC_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    input  logic                     macc_clear,
    output logic signed [ACC_W-1:0]  acc
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    acc_q;

    mac_mult #(.DATA_W(DATA_W)) u_mult (
        .a_i (A),
        .b_i (B),
        .p_o (prod)
    );

    // Size cast of a signed value sign-extends.
    assign prod_ext = ACC_W'(prod);

    // Plain ACC_W-bit add: overflow wraps, no saturation.
    always_comb begin
        acc_d = acc_q + prod_ext;
        if (macc_clear) acc_d = prod_ext;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: directed self-checking bench for mac_unit.
module tb_mac_unit;
    logic              clk;
    logic              rst_n;
    logic signed [7:0] A;
    logic signed [7:0] B;
    logic              macc_clear;
    logic signed [18:0] acc;

    int n_tests;
    int n_fail;

    mac_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .B          (B),
        .macc_clear (macc_clear),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply inputs, take one rising edge, settle, then the caller checks acc.
    task automatic step(input logic rn, input logic clr, input int a, input int b);
        rst_n      = rn;
        macc_clear = clr;
        A          = 8'(a);
        B          = 8'(b);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [18:0] mdl;
        int ra, rb;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; macc_clear = 1'b0; A = '0; B = '0;
        #2;

        // Reset with non-zero operands.
        step(1'b0, 1'b0, 5, 5);   chk("rst_edge1", acc, 0);
        step(1'b0, 1'b0, 5, 5);   chk("rst_edge2", acc, 0);
        step(1'b1, 1'b1, 0, 0);   chk("clear_zero", acc, 0);

        // Basic accumulate.
        step(1'b1, 1'b0, 3, 4);   chk("acc_3x4", acc, 12);
        step(1'b1, 1'b0, 2, 5);   chk("acc_2x5", acc, 22);

        // Clear-and-load, then continue.
        step(1'b1, 1'b1, 7, 6);   chk("clr_7x6", acc, 42);
        step(1'b1, 1'b0, 1, 3);   chk("acc_1x3", acc, 45);

        // Signed extremes.
        step(1'b1, 1'b1, 0, 0);   chk("clear_zero2", acc, 0);
        step(1'b1, 1'b0, -1, -1); chk("acc_m1xm1", acc, 1);
        step(1'b1, 1'b0, 127, 127); chk("acc_127x127", acc, 16130);
        step(1'b1, 1'b1, -128, 127); chk("clr_m128x127", acc, -16256);
        step(1'b1, 1'b1, -128, -128); chk("clr_m128xm128", acc, 16384);

        // Wrap-around: 16 products of 16384 = 2^18, which wraps to -2^18.
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, -128, -128);
            if (i < 14) chk("wrap_ramp", acc, 16384 * (i + 2));
            else        chk("wrap_final", acc, -262144);
        end
        step(1'b1, 1'b0, -128, -128); chk("wrap_past", acc, -245760);

        // Reset beats clear.
        step(1'b0, 1'b1, 7, 6);   chk("rst_prio", acc, 0);

        // Random pairs versus a wrapping model, starting from reset value 0.
        mdl = '0;
        for (int i = 0; i < 5; i++) begin
            ra = $urandom_range(255) - 128;
            rb = $urandom_range(255) - 128;
            step(1'b1, 1'b0, ra, rb);
            mdl = mdl + 19'(ra * rb);
            chk("rand_acc", acc, mdl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
